dev_protocol_resp: RTL and testbench

DEV_PROTOCOL_RESP -- requirements
Module: dev_protocol_resp

---
 rtl/dev_protocol_resp.sv | 189 ++++++++++++++++++
 tb/tb_dev_protocol_resp.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dev_protocol_resp.sv
// Device-side packet responder: answers OUT/IN tokens with handshakes or DATA0, owns a one-entry IN buffer.
// Optional error counter is built only when DEV_ERRCNT_EN is defined.
module dev_protocol_resp (
    input  logic        clk,
    input  logic        rst_L,
    input  logic        rx_valid,
    input  logic        rx_corrupted,
    input  logic [3:0]  rx_pid,
    input  logic [6:0]  rx_addr,
    input  logic [3:0]  rx_endp,
    input  logic [63:0] rx_data,
    input  logic [6:0]  dev_addr,
    input  logic [3:0]  dev_endp,
    input  logic        tx_busy,
    output logic        tx_pktready,
    output logic        tx_pkttype,
    output logic [3:0]  tx_pid,
    output logic [63:0] tx_data,
    output logic [63:0] app_out_data,
    output logic        app_out_valid,
    input  logic        app_out_stall,
    input  logic [63:0] app_in_data,
    input  logic        app_in_load,
    output logic        app_in_full,
    output logic [7:0]  err_cnt
);

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;

    typedef enum logic [2:0] {
        IDLE, OUT_WDATA, OUT_RESP, IN_SEND, IN_WACK
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  timer_q, timer_d;
    logic [3:0]  hs_q, hs_d;
    logic [63:0] out_data_q, out_data_d;
    logic [63:0] buf_q, buf_d;
    logic        full_q, full_d;
    logic        ack_clr, load_ok, pkt_ok, for_us;

    assign pkt_ok = rx_valid && !rx_corrupted;
    assign for_us = pkt_ok && (rx_addr == dev_addr) && (rx_endp == dev_endp);

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        hs_d          = hs_q;
        out_data_d    = out_data_q;
        tx_pktready   = 1'b0;
        tx_pkttype    = 1'b0;
        tx_pid        = 4'd0;
        tx_data       = 64'd0;
        app_out_valid = 1'b0;
        ack_clr       = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = 8'd0;
                if (for_us && rx_pid == PID_OUT) begin
                    state_d = OUT_WDATA;
                end else if (for_us && rx_pid == PID_IN) begin
                    if (full_q) begin
                        state_d = IN_SEND;
                    end else begin
                        hs_d    = PID_NAK;
                        state_d = OUT_RESP;
                    end
                end
            end
            OUT_WDATA: begin
                if (rx_valid) begin
                    // Any packet restarts the wait; stray tokens are otherwise ignored.
                    timer_d = 8'd0;
                    if (rx_corrupted || (rx_pid == PID_DATA0 && app_out_stall)) begin
                        hs_d    = PID_NAK;
                        state_d = OUT_RESP;
                    end else if (rx_pid == PID_DATA0) begin
                        out_data_d    = rx_data;
                        app_out_valid = 1'b1;
                        hs_d          = PID_ACK;
                        state_d       = OUT_RESP;
                    end
                end else if (timer_q == 8'hFF) begin
                    timer_d = 8'd0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            OUT_RESP: begin
                if (!tx_busy) begin
                    tx_pktready = 1'b1;
                    tx_pid      = hs_q;
                    state_d     = IDLE;
                end
            end
            IN_SEND: begin
                if (!tx_busy) begin
                    tx_pktready = 1'b1;
                    tx_pkttype  = 1'b1;
                    tx_pid      = PID_DATA0;
                    tx_data     = buf_q;
                    timer_d     = 8'd0;
                    state_d     = IN_WACK;
                end
            end
            IN_WACK: begin
                // Corrupted packets count as silence here.
                if (pkt_ok) begin
                    timer_d = 8'd0;
                    if (rx_pid == PID_ACK) begin
                        ack_clr = 1'b1;
                        state_d = IDLE;
                    end else if (rx_pid == PID_NAK) begin
                        state_d = IN_SEND;
                    end
                end else if (timer_q == 8'hFF) begin
                    timer_d = 8'd0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A load coinciding with the ACK that empties the buffer takes priority.
    assign load_ok = app_in_load && (!full_q || ack_clr);

    always_comb begin
        buf_d  = buf_q;
        full_d = full_q;
        if (ack_clr) full_d = 1'b0;
        if (load_ok) begin
            buf_d  = app_in_data;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_q    <= IDLE;
            timer_q    <= 8'd0;
            hs_q       <= 4'd0;
            out_data_q <= 64'd0;
            buf_q      <= 64'd0;
            full_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            hs_q       <= hs_d;
            out_data_q <= out_data_d;
            buf_q      <= buf_d;
            full_q     <= full_d;
        end
    end

    assign app_out_data = app_out_valid ? rx_data : out_data_q;
    assign app_in_full  = full_q;

`ifdef DEV_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       corr_evt, expire;

    assign corr_evt = rx_valid && rx_corrupted && (state_q != IDLE);
    assign expire   = (timer_q == 8'hFF) &&
                      ((state_q == OUT_WDATA && !rx_valid) || (state_q == IN_WACK && !pkt_ok));

    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((corr_evt || expire) && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) err_cnt_q <= 8'd0;
        else        err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_dev_protocol_resp.sv
// Directed bench for dev_protocol_resp: vector table for single-cycle behaviour, scripted timeout/busy/reset sequences.
module tb_dev_protocol_resp;

    localparam logic [3:0] P_OUT = 4'b0001, P_IN = 4'b1001, P_D0 = 4'b0011, P_ACK = 4'b0010, P_NAK = 4'b1010;
    localparam logic [63:0] X = 64'hAABBCCDD;
`ifdef DEV_ERRCNT_EN
    localparam bit ECEN = 1'b1;
`else
    localparam bit ECEN = 1'b0;
`endif

    logic        clk = 1'b0, rst_L = 1'b0;
    logic        rx_valid = 0, rx_corrupted = 0, tx_busy = 0, app_out_stall = 0, app_in_load = 0;
    logic [3:0]  rx_pid = 0, rx_endp = 4'h3, dev_endp = 4'h3;
    logic [6:0]  rx_addr = 0, dev_addr = 7'h07;
    logic [63:0] rx_data = 0, app_in_data = 0;
    logic        tx_pktready, tx_pkttype, app_out_valid, app_in_full;
    logic [3:0]  tx_pid;
    logic [63:0] tx_data, app_out_data;
    logic [7:0]  err_cnt;

    int npass = 0, ntot = 0;

    always #5 clk = ~clk;

    dev_protocol_resp dut (
        .clk(clk), .rst_L(rst_L), .rx_valid(rx_valid), .rx_corrupted(rx_corrupted),
        .rx_pid(rx_pid), .rx_addr(rx_addr), .rx_endp(rx_endp), .rx_data(rx_data),
        .dev_addr(dev_addr), .dev_endp(dev_endp), .tx_busy(tx_busy),
        .tx_pktready(tx_pktready), .tx_pkttype(tx_pkttype), .tx_pid(tx_pid), .tx_data(tx_data),
        .app_out_data(app_out_data), .app_out_valid(app_out_valid), .app_out_stall(app_out_stall),
        .app_in_data(app_in_data), .app_in_load(app_in_load), .app_in_full(app_in_full),
        .err_cnt(err_cnt)
    );

    typedef struct {
        string       nm;
        logic        vld, corr;
        logic [3:0]  pid;
        logic [6:0]  addr;
        logic [63:0] data;
        logic        busy, stall, load;
        logic [63:0] ind;
        logic        rdy, typ;
        logic [3:0]  tpid;
        logic [63:0] tdata;
        logic        aov;
        logic [63:0] aod;
        logic        full;
        logic [7:0]  ec;
    } vec_t;

    vec_t vq[$];

    function automatic logic [7:0] ecx(input int n);
        return ECEN ? 8'(n) : 8'd0;
    endfunction

    function automatic vec_t mk(input string nm, input logic vld, corr, input logic [3:0] pid,
                                input logic [6:0] addr, input logic [63:0] data, input logic busy, stall, load,
                                input logic [63:0] ind, input logic rdy, typ, input logic [3:0] tpid,
                                input logic [63:0] tdata, input logic aov, input logic [63:0] aod,
                                input logic full, input logic [7:0] ec);
        vec_t v;
        v.nm = nm; v.vld = vld; v.corr = corr; v.pid = pid; v.addr = addr; v.data = data;
        v.busy = busy; v.stall = stall; v.load = load; v.ind = ind; v.rdy = rdy; v.typ = typ;
        v.tpid = tpid; v.tdata = tdata; v.aov = aov; v.aod = aod; v.full = full; v.ec = ec;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step(input logic v, c, input logic [3:0] p, input logic [6:0] a, input logic [63:0] d,
                        input logic b, s, l, input logic [63:0] ind);
        @(negedge clk);
        rx_valid = v; rx_corrupted = c; rx_pid = p; rx_addr = a; rx_data = d;
        tx_busy = b; app_out_stall = s; app_in_load = l; app_in_data = ind;
        #1;
    endtask

    task automatic idle_step();
        step(0, 0, 4'd0, 7'd0, 64'd0, 0, 0, 0, 64'd0);
    endtask

    task automatic check_tx(input string nm, input logic rdy, typ, input logic [3:0] p, input logic [63:0] d);
        chk({nm, ".rdy"}, 64'(tx_pktready), 64'(rdy));
        chk({nm, ".typ"}, 64'(tx_pkttype), 64'(typ));
        chk({nm, ".pid"}, 64'(tx_pid), 64'(p));
        chk({nm, ".data"}, tx_data, d);
    endtask

    initial begin
        int e1, e2, e3;
        int bad;
        e1 = ecx(1); e2 = ecx(2); e3 = ecx(3);
        //            name            vld c pid    addr  data      b s l ind        rdy t tpid   tdata     aov aod    full ec
        vq.push_back(mk("rst_idle",     0,0,4'd0, 7'd0,64'd0,     0,0,0,64'd0,     0,0,4'd0, 64'd0,    0,64'd0, 0,8'd0));
        vq.push_back(mk("out_tok",      1,0,P_OUT,7'd7,64'd0,     0,0,0,64'd0,     0,0,4'd0, 64'd0,    0,64'd0, 0,8'd0));
        vq.push_back(mk("tok_in_wdata", 1,0,P_IN, 7'd7,64'd0,     0,0,0,64'd0,     0,0,4'd0, 64'd0,    0,64'd0, 0,8'd0));
        vq.push_back(mk("data0_ok",     1,0,P_D0, 7'd0,X,         0,0,0,64'd0,     0,0,4'd0, 64'd0,    1,X,     0,8'd0));
        vq.push_back(mk("ack_tx",       0,0,4'd0, 7'd0,64'd0,     0,0,0,64'd0,     1,0,P_ACK,64'd0,    0,X,     0,8'd0));
        vq.push_back(mk("after_ack",    0,0,4'd0, 7'd0,64'd0,     0,0,0,64'd0,     0,0,4'd0, 64'd0,    0,X,     0,8'd0));
        vq.push_back(mk("out_tok2",     1,0,P_OUT,7'd7,64'd0,     0,0,0,64'd0,     0,0,4'd0, 64'd0,    0,X,     0,8'd0));
        vq.push_back(mk("data0_corr",   1,1,P_D0, 7'd0,64'h5555,  0,0,0,64'd0,     0,0,4'd0, 64'd0,    0,X,     0,8'd0));
        vq.push_back(mk("corr_nak_tx",  0,0,4'd0, 7'd0,64'd0,     0,0,0,64'd0,     1,0,P_NAK,64'd0,    0,X,     0,8'(e1)));
        vq.push_back(mk("after_nak",    0,0,4'd0, 7'd0,64'd0,     0,0,0,64'd0,     0,0,4'd0, 64'd0,    0,X,     0,8'(e1)));
        vq.push_back(mk("out_tok3",     1,0,P_OUT,7'd7,64'd0,     0,0,0,64'd0,     0,0,4'd0, 64'd0,    0,X,     0,8'(e1)));
        vq.push_back(mk("data0_stall",  1,0,P_D0, 7'd0,64'h77,    0,1,0,64'd0,     0,0,4'd0, 64'd0,    0,X,     0,8'(e1)));
        vq.push_back(mk("stall_nak_tx", 0,0,4'd0, 7'd0,64'd0,     0,0,0,64'd0,     1,0,P_NAK,64'd0,    0,X,     0,8'(e1)));
        vq.push_back(mk("in_empty",     1,0,P_IN, 7'd7,64'd0,     0,0,0,64'd0,     0,0,4'd0, 64'd0,    0,X,     0,8'(e1)));
        vq.push_back(mk("in_empty_nak", 0,0,4'd0, 7'd0,64'd0,     0,0,0,64'd0,     1,0,P_NAK,64'd0,    0,X,     0,8'(e1)));
        vq.push_back(mk("in_mismatch",  1,0,P_IN, 7'd8,64'd0,     0,0,0,64'd0,     0,0,4'd0, 64'd0,    0,X,     0,8'(e1)));
        vq.push_back(mk("mismatch_qt",  0,0,4'd0, 7'd0,64'd0,     0,0,0,64'd0,     0,0,4'd0, 64'd0,    0,X,     0,8'(e1)));
        vq.push_back(mk("load_1234",    0,0,4'd0, 7'd0,64'd0,     0,0,1,64'h1234,  0,0,4'd0, 64'd0,    0,X,     0,8'(e1)));
        vq.push_back(mk("in_tok",       1,0,P_IN, 7'd7,64'd0,     0,0,0,64'd0,     0,0,4'd0, 64'd0,    0,X,     1,8'(e1)));
        vq.push_back(mk("in_busy",      0,0,4'd0, 7'd0,64'd0,     1,0,0,64'd0,     0,0,4'd0, 64'd0,    0,X,     1,8'(e1)));
        vq.push_back(mk("in_data_tx",   0,0,4'd0, 7'd0,64'd0,     0,0,0,64'd0,     1,1,P_D0, 64'h1234, 0,X,     1,8'(e1)));
        vq.push_back(mk("host_nak",     1,0,P_NAK,7'd0,64'd0,     0,0,0,64'd0,     0,0,4'd0, 64'd0,    0,X,     1,8'(e1)));
        vq.push_back(mk("load_drop",    0,0,4'd0, 7'd0,64'd0,     1,0,1,64'h9999,  0,0,4'd0, 64'd0,    0,X,     1,8'(e1)));
        vq.push_back(mk("retx",         0,0,4'd0, 7'd0,64'd0,     0,0,0,64'd0,     1,1,P_D0, 64'h1234, 0,X,     1,8'(e1)));
        vq.push_back(mk("wack_corr",    1,1,P_ACK,7'd0,64'd0,     0,0,0,64'd0,     0,0,4'd0, 64'd0,    0,X,     1,8'(e1)));
        vq.push_back(mk("host_ack",     1,0,P_ACK,7'd0,64'd0,     0,0,0,64'd0,     0,0,4'd0, 64'd0,    0,X,     1,8'(e2)));
        vq.push_back(mk("acked",        0,0,4'd0, 7'd0,64'd0,     0,0,0,64'd0,     0,0,4'd0, 64'd0,    0,X,     0,8'(e2)));
        vq.push_back(mk("load_abcd",    0,0,4'd0, 7'd0,64'd0,     0,0,1,64'hABCD,  0,0,4'd0, 64'd0,    0,X,     0,8'(e2)));
        vq.push_back(mk("in_tok_f",     1,0,P_IN, 7'd7,64'd0,     0,0,0,64'd0,     0,0,4'd0, 64'd0,    0,X,     1,8'(e2)));
        vq.push_back(mk("tx_abcd",      0,0,4'd0, 7'd0,64'd0,     0,0,0,64'd0,     1,1,P_D0, 64'hABCD, 0,X,     1,8'(e2)));
        vq.push_back(mk("ack_and_load", 1,0,P_ACK,7'd0,64'd0,     0,0,1,64'h5678,  0,0,4'd0, 64'd0,    0,X,     1,8'(e2)));
        vq.push_back(mk("reload_in",    1,0,P_IN, 7'd7,64'd0,     0,0,0,64'd0,     0,0,4'd0, 64'd0,    0,X,     1,8'(e2)));
        vq.push_back(mk("tx_5678",      0,0,4'd0, 7'd0,64'd0,     0,0,0,64'd0,     1,1,P_D0, 64'h5678, 0,X,     1,8'(e2)));
        vq.push_back(mk("host_ack2",    1,0,P_ACK,7'd0,64'd0,     0,0,0,64'd0,     0,0,4'd0, 64'd0,    0,X,     1,8'(e2)));
        vq.push_back(mk("empty_again",  0,0,4'd0, 7'd0,64'd0,     0,0,0,64'd0,     0,0,4'd0, 64'd0,    0,X,     0,8'(e2)));

        repeat (2) @(negedge clk);
        rst_L = 1'b1;

        foreach (vq[i]) begin
            step(vq[i].vld, vq[i].corr, vq[i].pid, vq[i].addr, vq[i].data,
                 vq[i].busy, vq[i].stall, vq[i].load, vq[i].ind);
            check_tx(vq[i].nm, vq[i].rdy, vq[i].typ, vq[i].tpid, vq[i].tdata);
            chk({vq[i].nm, ".aov"},  64'(app_out_valid), 64'(vq[i].aov));
            chk({vq[i].nm, ".aod"},  app_out_data, vq[i].aod);
            chk({vq[i].nm, ".full"}, 64'(app_in_full), 64'(vq[i].full));
            chk({vq[i].nm, ".ec"},   64'(err_cnt), 64'(vq[i].ec));
        end

        // Data arriving on the last cycle of the wait window is still accepted.
        step(1, 0, P_OUT, 7'd7, 64'd0, 0, 0, 0, 64'd0);
        bad = 0;
        repeat (255) begin idle_step(); if (tx_pktready) bad++; end
        chk("wait255.no_tx", 64'(bad), 64'd0);
        step(1, 0, P_D0, 7'd0, 64'h1111, 0, 0, 0, 64'd0);
        chk("wait255.aov", 64'(app_out_valid), 64'd1);
        chk("wait255.aod", app_out_data, 64'h1111);
        idle_step();
        check_tx("wait255.ack", 1, 0, P_ACK, 64'd0);

        // 256 silent cycles expire back to IDLE with no transmit.
        step(1, 0, P_OUT, 7'd7, 64'd0, 0, 0, 0, 64'd0);
        bad = 0;
        repeat (256) begin idle_step(); if (tx_pktready) bad++; end
        chk("timeout.no_tx", 64'(bad), 64'd0);
        step(1, 0, P_D0, 7'd0, 64'h2222, 0, 0, 0, 64'd0);
        chk("timeout.aov", 64'(app_out_valid), 64'd0);
        chk("timeout.ec", 64'(err_cnt), 64'(e3));
        idle_step();
        chk("timeout.late_rdy", 64'(tx_pktready), 64'd0);

        // Handshake held off by a busy transmitter.
        step(1, 0, P_OUT, 7'd7, 64'd0, 0, 0, 0, 64'd0);
        step(1, 0, P_D0, 7'd0, 64'h3333, 0, 0, 0, 64'd0);
        chk("busy.aov", 64'(app_out_valid), 64'd1);
        bad = 0;
        repeat (10) begin step(0, 0, 4'd0, 7'd0, 64'd0, 1, 0, 0, 64'd0); if (tx_pktready) bad++; end
        chk("busy.held", 64'(bad), 64'd0);
        idle_step();
        check_tx("busy.release", 1, 0, P_ACK, 64'd0);
        idle_step();
        chk("busy.single", 64'(tx_pktready), 64'd0);

        // Reset while waiting for the host's ACK.
        step(0, 0, 4'd0, 7'd0, 64'd0, 0, 0, 1, 64'h42);
        step(1, 0, P_IN, 7'd7, 64'd0, 0, 0, 0, 64'd0);
        idle_step();
        check_tx("rst.pre_tx", 1, 1, P_D0, 64'h42);
        idle_step();
        #1 rst_L = 1'b0;
        #1;
        check_tx("rst.low", 0, 0, 4'd0, 64'd0);
        chk("rst.aov",  64'(app_out_valid), 64'd0);
        chk("rst.aod",  app_out_data, 64'd0);
        chk("rst.full", 64'(app_in_full), 64'd0);
        chk("rst.ec",   64'(err_cnt), 64'd0);
        @(negedge clk);
        rst_L = 1'b1;
        bad = 0;
        repeat (20) begin idle_step(); if (tx_pktready || app_in_full) bad++; end
        chk("rst.quiet", 64'(bad), 64'd0);
        step(1, 0, P_IN, 7'd7, 64'd0, 0, 0, 0, 64'd0);
        idle_step();
        check_tx("rst.in_nak", 1, 0, P_NAK, 64'd0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
